sub_nbit_reg: RTL and testbench
===============================

Name: sub_nbit_reg

Overview:
Registered N-bit two's-complement subtractor computing S = A − B, with status flags, for the floating-point adder/subtractor datapath (exponent difference / mantissa subtract). The combinational core is a ripple-borrow chain of N full-subtractor cells. Result and flags are captured on the rising clock edge, giving one cycle of latency.

Parameters:
N, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
A  input  N  minuend, two's complement, also usable as unsigned
B  input  N  subtrahend, two's complement, also usable as unsigned
S  output  N  registered difference A − B modulo 2^N
borrow  output  1  registered unsigned borrow-out: 1 when A < B as unsigned
ovf  output  1  registered signed overflow: true result outside [−2^(N−1), 2^(N−1)−1]
neg  output  1  registered sign: equals S[N−1]
zero  output  1  registered: 1 when S == 0

Behaviour:
- Core: ripple-borrow chain over bits 0..N−1, borrow-in of bit 0 = 0.
  - d[i] = A[i] ^ B[i] ^ bin[i]
  - bout[i] = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & bin[i])
- Flags:
  - borrow = bout[N−1].
  - ovf = (A[N−1] != B[N−1]) && (d[N−1] != A[N−1]).
  - zero = (d == 0).
  - neg = d[N−1].
- Register stage: on posedge clk, S, borrow, ovf, neg and zero all load from the core outputs of the inputs sampled at that edge.
- Latency is exactly 1 cycle. No handshake: a new operation is accepted every cycle and outputs are updated every cycle.
- Reset:
  - rst_n low asynchronously forces S = 0, borrow = 0, ovf = 0, neg = 0, zero = 0, independent of clk.
  - zero reads 0 during reset, by decision, even though S = 0.
  - The first capture happens on the first posedge after rst_n is released.
  - Reset asserted mid-stream discards the pending result. No state other than the output registers exists.
- Wrap-around: results are modulo 2^N with no saturation. Overflow is reported only through ovf.
- X on A or B propagates to the outputs. No X masking is required.
- Inputs change between edges (non-blocking stimulus): only the values present at the edge matter.

Test Plan:
- Reset: hold rst_n = 0 with A = 8'd5, B = 8'd10 toggling clk -> S = 0, all flags 0. Assert rst_n low asynchronously mid-cycle after a nonzero result -> outputs clear immediately, without waiting for an edge.
- A = 5, B = 10 -> next cycle S = 8'hFB (−5), borrow = 1, neg = 1, ovf = 0, zero = 0.
- A = 30, B = −10 (8'hF6) -> S = 8'h28 (40), borrow = 1, neg = 0, ovf = 0, zero = 0.
- A = 127, B = −1 (8'hFF) -> S = 8'h80, ovf = 1, neg = 1, borrow = 1.
- A = −128 (8'h80), B = 1 -> S = 8'h7F, ovf = 1, neg = 0, borrow = 0. Then A = 8'h55, B = 8'h55 -> S = 0, zero = 1, all other flags 0.
- Back-to-back random A, B in [−128, 127] for at least 10 consecutive cycles -> each cycle's S equals (A − B) mod 256 from the previous edge, and the flags match a reference model.

Source files
------------

// File: rtl/sub_nbit_reg.sv
// sub_nbit_reg: registered N-bit two's-complement subtractor S = A - B.
// A ripple-borrow chain of full-subtractor cells forms the difference and
// status flags; one register stage captures them on the rising clock edge.
module sub_nbit_reg #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] S,
  output logic         borrow,
  output logic         ovf,
  output logic         neg,
  output logic         zero
);

  logic [N-1:0] s_d;
  logic [N-1:0] s_q;
  logic [N:0]   bin;
  logic         borrow_d;
  logic         borrow_q;
  logic         ovf_d;
  logic         ovf_q;
  logic         neg_d;
  logic         neg_q;
  logic         zero_d;
  logic         zero_q;

  // Ripple-borrow chain: each cell takes the borrow from the cell below it.
  always_comb begin
    bin    = '0;
    s_d    = '0;
    bin[0] = 1'b0;
    for (int i = 0; i < N; i++) begin
      s_d[i]   = A[i] ^ B[i] ^ bin[i];
      bin[i+1] = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & bin[i]);
    end
  end

  // Status flags derived from the chain: unsigned borrow, signed overflow
  // (operand signs differ and the result sign departs from the minuend),
  // sign and zero.
  always_comb begin
    borrow_d = bin[N];
    ovf_d    = (A[N-1] != B[N-1]) && (s_d[N-1] != A[N-1]);
    neg_d    = s_d[N-1];
    zero_d   = (s_d == '0);
  end

  // Output register; reset clears everything, including zero, so the
  // flags read all-quiet until the first real result is captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q      <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      s_q      <= s_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      neg_q    <= neg_d;
      zero_q   <= zero_d;
    end
  end

  assign S      = s_q;
  assign borrow = borrow_q;
  assign ovf    = ovf_q;
  assign neg    = neg_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_sub_nbit_reg.sv
// tb_sub_nbit_reg: directed and back-to-back random checks of the
// registered subtractor, including asynchronous reset behaviour.
module tb_sub_nbit_reg;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] S;
  logic         borrow;
  logic         ovf;
  logic         neg;
  logic         zero;

  int checks = 0;
  int errors = 0;

  sub_nbit_reg #(.N(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (A),
    .B      (B),
    .S      (S),
    .borrow (borrow),
    .ovf    (ovf),
    .neg    (neg),
    .zero   (zero)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive operands, then wait for the capturing edge and settle past it.
  task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b);
    A = a;
    B = b;
    @(posedge clk);
    #1;
  endtask

  // Compare every output against the expected set.
  task automatic checkOutput(input string tag, input logic [N-1:0] exp_s,
                             input logic exp_b, input logic exp_o,
                             input logic exp_n, input logic exp_z);
    checks++;
    assert (S === exp_s) else begin
      errors++;
      $error("[TB] FAIL %s.S: observed %h expected %h", tag, S, exp_s);
    end
    checks++;
    assert (borrow === exp_b) else begin
      errors++;
      $error("[TB] FAIL %s.borrow: observed %b expected %b", tag, borrow, exp_b);
    end
    checks++;
    assert (ovf === exp_o) else begin
      errors++;
      $error("[TB] FAIL %s.ovf: observed %b expected %b", tag, ovf, exp_o);
    end
    checks++;
    assert (neg === exp_n) else begin
      errors++;
      $error("[TB] FAIL %s.neg: observed %b expected %b", tag, neg, exp_n);
    end
    checks++;
    assert (zero === exp_z) else begin
      errors++;
      $error("[TB] FAIL %s.zero: observed %b expected %b", tag, zero, exp_z);
    end
  endtask

  // Reference model using plain integer arithmetic.
  task automatic modelCheck(input string tag, input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0]   wide;
    int           sres;
    logic [N-1:0] es;
    wide = {1'b0, a} - {1'b0, b};
    sres = int'($signed(a)) - int'($signed(b));
    es   = wide[N-1:0];
    checkOutput(tag, es, wide[N], (sres > 127) || (sres < -128), es[N-1], es == '0);
  endtask

  initial begin
    logic [N-1:0] ra;
    logic [N-1:0] rb;

    rst_n = 1'b0;
    A = 8'd5;
    B = 8'd10;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_hold", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(8'd5, 8'd10);
    checkOutput("5_minus_10", 8'hFB, 1'b1, 1'b0, 1'b1, 1'b0);

    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(8'd30, 8'hF6);
    checkOutput("30_minus_m10", 8'h28, 1'b1, 1'b0, 1'b0, 1'b0);

    applyStimulus(8'd127, 8'hFF);
    checkOutput("127_minus_m1", 8'h80, 1'b1, 1'b1, 1'b1, 1'b0);

    applyStimulus(8'h80, 8'd1);
    checkOutput("m128_minus_1", 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0);

    applyStimulus(8'h55, 8'h55);
    checkOutput("equal_ops", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    applyStimulus(8'h00, 8'h01);
    checkOutput("0_minus_1", 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);

    applyStimulus(8'h00, 8'h80);
    checkOutput("0_minus_m128", 8'h80, 1'b1, 1'b1, 1'b1, 1'b0);

    applyStimulus(8'hC8, 8'h0A);
    checkOutput("m56_minus_10", 8'hBE, 1'b0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 16; i++) begin
      ra = N'($urandom_range(0, 255));
      rb = N'($urandom_range(0, 255));
      applyStimulus(ra, rb);
      modelCheck($sformatf("rand%0d", i), ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
